// File: rtl/mult_operand_feeder.sv
`default_nettype none
// ============================================================================
// Module      : mult_operand_feeder
// Description : Operand feeder that sits in front of a PERIOD-stage
//               combinational multiplier. Operand pairs (a, b, tag) arrive on
//               a valid/ready interface and are queued in a small FIFO. One
//               pair per multiplier frame is loaded into a hold register and
//               presented on mul_in1/mul_in2 for the whole frame. res_due
//               flags the final phase of that frame, carrying the tag.
//
// Ports       : clk, rst_n              clock, synchronous active-low reset
//               in_valid/in_ready      operand handshake (in_ready = !full)
//               in_a, in_b, in_tag     operand pair and user tag
//               mul_in1, mul_in2       held operands for the multiplier
//               issue                  phase 0 of a frame carrying a pair
//               phase                  current frame phase 0..PERIOD-1
//               res_due, res_tag       product valid this cycle, and its tag
//               stat_issued, stat_idle (MULT_FEED_STATS_EN only) saturating
//                                      issued / idle frame counters
//
// Options     : `define MULT_FEED_STATS_EN to add the statistics counters.
//
// Revision    : 1.0 - initial release
// ============================================================================
module mult_operand_feeder #(
  parameter int DEPTH  = 4,
  parameter int PERIOD = 10,
  parameter int TAG_W  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [7:0]                in_a,
  input  logic [7:0]                in_b,
  input  logic [TAG_W-1:0]          in_tag,
  output logic [7:0]                mul_in1,
  output logic [7:0]                mul_in2,
  output logic                      issue,
  output logic [$clog2(PERIOD)-1:0] phase,
  output logic                      res_due,
  output logic [TAG_W-1:0]          res_tag
`ifdef MULT_FEED_STATS_EN
  ,
  output logic [15:0]               stat_issued,
  output logic [15:0]               stat_idle
`endif
);

  localparam int PH_W = $clog2(PERIOD);
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int EW   = 16 + TAG_W;

  localparam logic [PH_W-1:0] LAST_PH  = PH_W'(PERIOD - 1);
  localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);

  // FIFO storage, packed as {a, b, tag}
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic [PH_W-1:0]  phase_cnt;
  logic [7:0]       hold_a;
  logic [7:0]       hold_b;
  logic [TAG_W-1:0] hold_tag;
  logic             hold_valid;

  logic full;
  logic empty;
  logic load;
  logic push;
  logic pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  // The load edge is the clock edge that closes the last phase of a frame.
  assign load  = (phase_cnt == LAST_PH);

  // No pop credit: a full FIFO refuses even on a load edge. Gated by rst_n so
  // nothing is accepted while reset is being applied.
  assign in_ready = rst_n && !full;
  assign push     = in_valid && in_ready;
  assign pop      = load && !empty;

  // Storage is written without reset; occupancy is governed by count/pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_a, in_b, in_tag};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_cnt  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      hold_a     <= '0;
      hold_b     <= '0;
      hold_tag   <= '0;
      hold_valid <= 1'b0;
    end else begin
      phase_cnt <= load ? '0 : phase_cnt + PH_W'(1);

      // DEPTH is a power of two, so the pointers wrap naturally.
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      // The head read here reflects the FIFO before this edge's push, so a
      // pair written into an empty FIFO on the load edge waits a full frame.
      if (load) begin
        if (!empty) begin
          {hold_a, hold_b, hold_tag} <= mem[rd_ptr];
          hold_valid                 <= 1'b1;
        end else begin
          hold_a     <= '0;
          hold_b     <= '0;
          hold_tag   <= '0;
          hold_valid <= 1'b0;
        end
      end
    end
  end

  // Hold register is zeroed whenever it is invalid, so it drives out directly.
  assign mul_in1 = hold_a;
  assign mul_in2 = hold_b;
  assign phase   = phase_cnt;
  assign issue   = hold_valid && (phase_cnt == '0);
  assign res_due = hold_valid && load;
  assign res_tag = res_due ? hold_tag : '0;

`ifdef MULT_FEED_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_issued <= '0;
      stat_idle   <= '0;
    end else begin
      if (issue && (stat_issued != 16'hFFFF)) begin
        stat_issued <= stat_issued + 16'd1;
      end
      if ((phase_cnt == '0) && !issue && (stat_idle != 16'hFFFF)) begin
        stat_idle <= stat_idle + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mult_operand_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_operand_feeder
// Description : Self-checking bench for mult_operand_feeder. Directed frames
//               from the test plan followed by randomized traffic with
//               occasional resets, all compared each cycle against a
//               queue-based reference model of the feeder's rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_operand_feeder;

  localparam int DEPTH  = 4;
  localparam int PERIOD = 10;
  localparam int TAG_W  = 4;
  localparam int PH_W   = $clog2(PERIOD);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic [TAG_W-1:0] in_tag;
  logic [7:0]       mul_in1;
  logic [7:0]       mul_in2;
  logic             issue;
  logic [PH_W-1:0]  phase;
  logic             res_due;
  logic [TAG_W-1:0] res_tag;
`ifdef MULT_FEED_STATS_EN
  logic [15:0]      stat_issued;
  logic [15:0]      stat_idle;
`endif

  always #5 clk = ~clk;

  mult_operand_feeder #(
    .DEPTH  (DEPTH),
    .PERIOD (PERIOD),
    .TAG_W  (TAG_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_tag   (in_tag),
    .mul_in1  (mul_in1),
    .mul_in2  (mul_in2),
    .issue    (issue),
    .phase    (phase),
    .res_due  (res_due),
    .res_tag  (res_tag)
`ifdef MULT_FEED_STATS_EN
    ,
    .stat_issued (stat_issued),
    .stat_idle   (stat_idle)
`endif
  );

  // Reference model: a queue of pending pairs, the pair owning the current
  // frame, and the phase derived from cycles elapsed since reset.
  typedef struct {
    int a;
    int b;
    int tag;
  } pair_t;

  pair_t m_q[$];
  pair_t m_hold;
  bit    m_hv;
  int    m_cyc;       // cycles since reset release
  int    m_issued;
  int    m_idle;
  bit    known;

  int tests;
  int fails;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs against the model, then
  // advance the model across the coming rising edge.
  task automatic cycle(input bit rst_v, input bit v, input int a, input int b, input int t);
    int  ph;
    bit  exp_iss;
    bit  exp_due;
    bit  acc;
    rst_n    = rst_v;
    in_valid = v;
    in_a     = 8'(a);
    in_b     = 8'(b);
    in_tag   = TAG_W'(t);
    #1;
    ph      = m_cyc % PERIOD;
    exp_iss = m_hv && (ph == 0);
    exp_due = m_hv && (ph == PERIOD - 1);
    if (known) begin
      check("in_ready", 32'(in_ready), 32'(rst_v && (m_q.size() < DEPTH)));
      check("phase",    32'(phase),    32'(ph));
      check("issue",    32'(issue),    32'(exp_iss));
      check("res_due",  32'(res_due),  32'(exp_due));
      check("res_tag",  32'(res_tag),  exp_due ? 32'(m_hold.tag) : 32'd0);
      check("mul_in1",  32'(mul_in1),  m_hv ? 32'(m_hold.a) : 32'd0);
      check("mul_in2",  32'(mul_in2),  m_hv ? 32'(m_hold.b) : 32'd0);
      if (exp_due) begin
        check("product", 32'(mul_in1) * 32'(mul_in2), 32'(m_hold.a * m_hold.b));
      end
`ifdef MULT_FEED_STATS_EN
      check("stat_issued", 32'(stat_issued), 32'(m_issued));
      check("stat_idle",   32'(stat_idle),   32'(m_idle));
`endif
    end

    if (!rst_v) begin
      m_q.delete();
      m_hold   = '{0, 0, 0};
      m_hv     = 1'b0;
      m_cyc    = 0;
      m_issued = 0;
      m_idle   = 0;
      known    = 1'b1;
    end else begin
      acc = v && (m_q.size() < DEPTH);
      if (ph == 0) begin
        if (exp_iss) begin
          if (m_issued < 65535) m_issued++;
        end else begin
          if (m_idle < 65535) m_idle++;
        end
      end
      // Frame boundary: next frame takes the oldest queued pair, if any.
      if (ph == PERIOD - 1) begin
        if (m_q.size() > 0) begin
          m_hold = m_q.pop_front();
          m_hv   = 1'b1;
        end else begin
          m_hold = '{0, 0, 0};
          m_hv   = 1'b0;
        end
      end
      if (acc) begin
        m_q.push_back('{a & 255, b & 255, t & ((1 << TAG_W) - 1)});
      end
      m_cyc++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 0, 0, 0);
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 0, 0, 0);
    cycle(1'b0, 1'b0, 0, 0, 0);
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    known    = 1'b0;
    m_hv     = 1'b0;
    m_cyc    = 0;
    m_issued = 0;
    m_idle   = 0;
    m_hold   = '{0, 0, 0};

    // Single pair pushed at cycle 2: issued at 10, result flagged at 19.
    do_reset();
    idle(2);
    cycle(1'b1, 1'b1, 3, 5, 1);
    idle(18);

    // Four back-to-back pushes fill the FIFO; the fifth offer stalls.
    do_reset();
    cycle(1'b1, 1'b1, 255, 255, 2);
    cycle(1'b1, 1'b1, 1, 2, 3);
    cycle(1'b1, 1'b1, 10, 20, 4);
    cycle(1'b1, 1'b1, 7, 7, 5);
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, 9, 9, 6);
    idle(45);

    // Empty FIFO for three frames.
    do_reset();
    idle(31);

    // Push exactly on the load edge into an empty FIFO: waits a frame.
    do_reset();
    idle(9);
    cycle(1'b1, 1'b1, 7, 9, 3);
    idle(21);

    // Reset mid-operation with two queued and one held.
    do_reset();
    cycle(1'b1, 1'b1, 11, 12, 7);
    cycle(1'b1, 1'b1, 13, 14, 8);
    cycle(1'b1, 1'b1, 15, 16, 9);
    idle(11);
    cycle(1'b0, 1'b0, 0, 0, 0);
    idle(25);
    cycle(1'b1, 1'b1, 200, 100, 10);
    idle(20);

    // Randomized traffic with rare resets.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 299) != 0), ($urandom_range(0, 2) != 0),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, (1 << TAG_W) - 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mult_operand_feeder.md
Name: mult_operand_feeder

Overview:
- Upstream stage of the 10-phase combinational multiplier example. It buffers operand pairs arriving on a valid/ready interface and presents exactly one pair per multiplier frame on `mul_in1`/`mul_in2`, aligned to the multiplier's capture phase 0.
- It tracks the frame phase itself and pulses `res_due` with the operation tag in the phase where the multiplier's 16-bit result is valid (phase 9), so downstream logic can sample the product without decoding the multiplier's internal stage.

Parameters:
- DEPTH, 4, operand FIFO entries; power of two, minimum 2.
- PERIOD, 10, frame length in cycles; phase counts 0..PERIOD-1; must match the multiplier's stage count.
- TAG_W, 4, width of the user tag carried with each operand pair.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operand pair offered
- in_ready  output  1  feeder can accept; equals !full
- in_a  input  8  operand 1
- in_b  input  8  operand 2
- in_tag  input  TAG_W  tag for this pair
- mul_in1  output  8  to multiplier in1
- mul_in2  output  8  to multiplier in2
- issue  output  1  high during phase 0 when a valid pair is presented
- phase  output  $clog2(PERIOD)  current frame phase
- res_due  output  1  high during phase PERIOD-1 of a frame that issued a pair
- res_tag  output  TAG_W  tag of the pair whose product is valid; 0 when !res_due

Behaviour:
- Reset is sampled on the clk edge when rst_n=0. It clears phase to 0, empties the FIFO, and clears the hold register and hold_valid.
  - During reset, in_ready=0; all other outputs are 0.
- Phase counter:
  - +1 each cycle after reset; wraps PERIOD-1 -> 0.
  - The first cycle after rst_n rises is phase 0.
  - Integration releases rst_n so that this cycle coincides with multiplier stage 0.
- FIFO:
  - Push when in_valid && in_ready. in_ready = !full, with no same-cycle pop credit.
  - Push and pop can happen on the same edge when the FIFO is neither full nor empty.
  - Pointers wrap modulo DEPTH. The count is tracked explicitly; full = (count==DEPTH).
- Load edge is the clk edge at the end of phase PERIOD-1:
  - If the FIFO is non-empty: pop the head into the hold register (a, b, tag) and set hold_valid=1.
  - Otherwise: clear the hold register to 0 and set hold_valid=0.
  - No bypass: the load uses FIFO contents from before that edge's push. A pair pushed on the load edge into an empty FIFO waits a full frame.
- Hold register outputs:
  - mul_in1/mul_in2 are driven from the hold register and stay stable for the whole frame (phases 0..PERIOD-1).
  - They are 0 when hold_valid=0.
- issue = hold_valid && (phase==0).
- res_due = hold_valid && (phase==PERIOD-1). res_tag = hold tag under the same condition, else 0.
- Latency:
  - A pair accepted at phase j of frame n is issued at phase 0 of frame n+1 if it is at the FIFO head.
  - Its result is flagged PERIOD-1 cycles later.
- Ordering: strict FIFO; throughput is at most one pair per PERIOD cycles.
- Reset mid-operation: the FIFO and hold contents are discarded and no res_due is produced for them. Phase alignment is preserved only if the multiplier restarts at stage 0 on the same cycle.
- All outputs are registered or decoded from registered state; no combinational path from the in_* ports to the mul_* ports.

Optional Feature:
- Macro: MULT_FEED_STATS_EN.
- Defined: adds two outputs.
  - stat_issued[15:0]: +1 on every cycle with issue=1.
  - stat_idle[15:0]: +1 on every phase-0 cycle with issue=0.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: neither the ports nor the counters exist; all other behaviour is identical.

Test Plan:
- Reset release, push (a=3, b=5, tag=1) at cycle 2:
  - cycles 10..19: mul_in1=3, mul_in2=5.
  - issue=1 at cycle 10 only.
  - res_due=1 at cycle 19 with res_tag=1; attached multiplier out=15 at cycle 19.
- Push 4 pairs back-to-back from cycle 0 (DEPTH=4):
  - in_ready=0 after the 4th push.
  - The 5th offer stalls until the pop at the cycle 9 edge; in_ready=1 at cycle 10.
  - Issues occur at cycles 10, 20, 30, 40 in push order (e.g. 255*255 gives out=65025 at cycle 19).
- Empty FIFO for 3 frames:
  - issue=0, res_due=0, mul_in1=mul_in2=0 throughout.
  - With MULT_FEED_STATS_EN: stat_idle=3 and stat_issued=0 at cycle 30.
- Push (7, 9) exactly on the cycle-9 load edge into an empty FIFO:
  - Not issued at cycle 10; issued at cycle 20.
  - res_due at cycle 29 with out=63.
- Assert rst_n=0 at cycle 14 with 2 pairs queued and 1 in hold:
  - Outputs are 0 from cycle 15.
  - No res_due occurs until new pairs are pushed after release.
  - The phase restarts at 0.
